skewed_operand_feeder: RTL and testbench

//  Accepts one operand matrix as MATRIX_SIZE BRAM rows over a valid/ready handshake.

---
 rtl/skewed_operand_feeder_pkg.sv | 22 ++
 rtl/skewed_operand_feeder_if.sv | 38 +++
 rtl/skewed_operand_feeder_shifter.sv | 41 ++++
 rtl/skewed_operand_feeder.sv | 152 +++++++++++++++
 tb/tb_skewed_operand_feeder.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/skewed_operand_feeder_pkg.sv
// ---------------------------------------------------------------------------
// feeder_pkg
//   Shared types and helpers for the skewed operand feeder.
//   - feeder_state_t : frame sequencing states
//   - phase_w()      : bit width needed to count n values, never below 1
// ---------------------------------------------------------------------------
package feeder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    DONE
  } feeder_state_t;

  // $clog2 collapses to 0 for n<=1, which would give zero-width counters.
  function automatic int phase_w(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/skewed_operand_feeder_if.sv
// ---------------------------------------------------------------------------
// skewed_operand_feeder_if
//   Bundles the feeder's control, BRAM-side and array-side signals.
//   Parameters : REG_WIDTH (element bits), MATRIX_SIZE (elements per row)
//   Signals    : start, in_data/in_valid/in_ready (row input),
//                out_lanes/out_valid/out_ready (lane output),
//                compute_start, frame_done, busy (frame status)
//   Modports   : slave  - the feeder itself
//                master - whoever drives rows and consumes lanes
// ---------------------------------------------------------------------------
interface skewed_operand_feeder_if #(
  parameter int REG_WIDTH   = 16,
  parameter int MATRIX_SIZE = 4
);
  localparam int ARRAY_SIZE = 2 * MATRIX_SIZE - 1;

  logic                              start;
  logic [MATRIX_SIZE*REG_WIDTH-1:0]  in_data;
  logic                              in_valid;
  logic                              in_ready;
  logic [ARRAY_SIZE*REG_WIDTH-1:0]   out_lanes;
  logic                              out_valid;
  logic                              out_ready;
  logic                              compute_start;
  logic                              frame_done;
  logic                              busy;

  modport slave (
    input  start, in_data, in_valid, out_ready,
    output in_ready, out_lanes, out_valid, compute_start, frame_done, busy
  );

  modport master (
    output start, in_data, in_valid, out_ready,
    input  in_ready, out_lanes, out_valid, compute_start, frame_done, busy
  );

endinterface

// File: rtl/skewed_operand_feeder_shifter.sv
// ---------------------------------------------------------------------------
// skew_lane_shifter
//   Combinational placement of one matrix row onto the array's edge lanes.
//   Element i lands on lane phase+i; every other lane is zero.
//   Build option FEEDER_MIRROR_EN: element i lands on lane
//   ARRAY_SIZE-1-(phase+i) instead (top-edge / B-operand feeder).
//   Ports:
//     row   in  MATRIX_SIZE*REG_WIDTH  element i at [i*REG_WIDTH +: REG_WIDTH]
//     phase in  PHASE_W                row index within the frame
//     lanes out ARRAY_SIZE*REG_WIDTH   lane j at [j*REG_WIDTH +: REG_WIDTH]
// ---------------------------------------------------------------------------
module skew_lane_shifter
  import feeder_pkg::*;
#(
  parameter int REG_WIDTH   = 16,
  parameter int MATRIX_SIZE = 4,
  parameter int PHASE_W     = phase_w(MATRIX_SIZE)
) (
  input  logic [MATRIX_SIZE*REG_WIDTH-1:0]     row,
  input  logic [PHASE_W-1:0]                   phase,
  output logic [(2*MATRIX_SIZE-1)*REG_WIDTH-1:0] lanes
);

  localparam int ARRAY_SIZE = 2 * MATRIX_SIZE - 1;

  // Clear every lane, then drop each element onto its skewed lane.
  // phase never exceeds MATRIX_SIZE-1, so the target lane stays in range.
  always_comb begin
    lanes = '0;
    for (int i = 0; i < MATRIX_SIZE; i++) begin
`ifdef FEEDER_MIRROR_EN
      lanes[(ARRAY_SIZE - 1 - (int'(phase) + i)) * REG_WIDTH +: REG_WIDTH] =
        row[i*REG_WIDTH +: REG_WIDTH];
`else
      lanes[(int'(phase) + i) * REG_WIDTH +: REG_WIDTH] =
        row[i*REG_WIDTH +: REG_WIDTH];
`endif
    end
  end

endmodule

// File: rtl/skewed_operand_feeder.sv
// ---------------------------------------------------------------------------
// skewed_operand_feeder
//   Takes one MATRIX_SIZE x MATRIX_SIZE operand matrix row by row from a BRAM
//   read port and feeds it to the systolic array's edge lanes with a diagonal
//   skew (row k starts at lane k). A frame is: compute_start with the first
//   row beat, MATRIX_SIZE row beats, FLUSH_BEATS all-zero beats, then a
//   one-cycle frame_done after the last beat has been consumed.
//   Build option FEEDER_MIRROR_EN mirrors the lane mapping (see shifter).
//   Ports:
//     clk    in  rising-edge clock
//     reset  in  synchronous, active-high; abandons any frame in progress
//     bus    skewed_operand_feeder_if.slave
//            start, in_data/in_valid/in_ready, out_lanes/out_valid/out_ready,
//            compute_start, frame_done, busy
// ---------------------------------------------------------------------------
module skewed_operand_feeder
  import feeder_pkg::*;
#(
  parameter int REG_WIDTH   = 16,
  parameter int MATRIX_SIZE = 4,
  parameter int FLUSH_BEATS = MATRIX_SIZE - 1
) (
  input  logic                    clk,
  input  logic                    reset,
  skewed_operand_feeder_if.slave  bus
);

  localparam int ARRAY_SIZE = 2 * MATRIX_SIZE - 1;
  localparam int LANES_W    = ARRAY_SIZE * REG_WIDTH;
  localparam int PHASE_W    = phase_w(MATRIX_SIZE);
  localparam int FLUSH_W    = phase_w(FLUSH_BEATS + 1);

  feeder_state_t        state;
  feeder_state_t        state_nxt;
  logic [PHASE_W-1:0]   phase;
  logic [FLUSH_W-1:0]   flush_cnt;
  logic [LANES_W-1:0]   lanes_q;
  logic [LANES_W-1:0]   shifted;
  logic                 out_valid_q;
  logic                 compute_start_q;
  logic                 frame_done_q;

  logic                 can_advance;
  logic                 consume;
  logic                 in_ready_c;
  logic                 accept;
  logic                 flush_emit;
  logic                 done_fire;

  // The output register may take a new beat whenever it is empty or its
  // current beat is being consumed this cycle.
  assign can_advance = !out_valid_q || bus.out_ready;
  assign consume     = out_valid_q && bus.out_ready;

  skew_lane_shifter #(
    .REG_WIDTH   (REG_WIDTH),
    .MATRIX_SIZE (MATRIX_SIZE),
    .PHASE_W     (PHASE_W)
  ) u_shifter (
    .row   (bus.in_data),
    .phase (phase),
    .lanes (shifted)
  );

  // Next-state and per-cycle strobes. Rows are only accepted in LOAD,
  // zero beats only generated in FLUSH, and DONE waits for the last beat
  // to leave the output register before announcing the end of the frame.
  always_comb begin
    state_nxt  = state;
    in_ready_c = 1'b0;
    accept     = 1'b0;
    flush_emit = 1'b0;
    done_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = LOAD;
      end
      LOAD: begin
        in_ready_c = can_advance;
        accept     = can_advance && bus.in_valid;
        if (accept && int'(phase) == MATRIX_SIZE - 1)
          state_nxt = (FLUSH_BEATS == 0) ? DONE : FLUSH;
      end
      FLUSH: begin
        flush_emit = can_advance;
        if (flush_emit && int'(flush_cnt) == FLUSH_BEATS - 1)
          state_nxt = DONE;
      end
      DONE: begin
        done_fire = can_advance;
        if (done_fire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Row phase and flush counters. Both restart whenever the feeder is idle,
  // so every frame begins at phase 0. phase sticks at its last value after
  // the final row rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase     <= '0;
      flush_cnt <= '0;
    end else if (state == IDLE) begin
      phase     <= '0;
      flush_cnt <= '0;
    end else begin
      if (accept && int'(phase) != MATRIX_SIZE - 1) phase <= phase + 1'b1;
      if (flush_emit) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  // Output register. A new row or flush beat replaces the current one in the
  // same cycle it is consumed, giving back-to-back beats; with nothing new to
  // load, a consumed beat simply drops out_valid. Under stall everything holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      lanes_q         <= '0;
      out_valid_q     <= 1'b0;
      compute_start_q <= 1'b0;
      frame_done_q    <= 1'b0;
    end else begin
      frame_done_q <= done_fire;
      if (accept) begin
        lanes_q         <= shifted;
        out_valid_q     <= 1'b1;
        compute_start_q <= (phase == '0);
      end else if (flush_emit) begin
        lanes_q         <= '0;
        out_valid_q     <= 1'b1;
        compute_start_q <= 1'b0;
      end else if (consume) begin
        out_valid_q     <= 1'b0;
        compute_start_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready      = in_ready_c;
  assign bus.out_lanes     = lanes_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.compute_start = compute_start_q;
  assign bus.frame_done    = frame_done_q;
  assign bus.busy          = (state != IDLE);

endmodule

// File: tb/tb_skewed_operand_feeder.sv
// ---------------------------------------------------------------------------
// tb_skewed_operand_feeder
//   Directed bench for skewed_operand_feeder (REG_WIDTH=16, MATRIX_SIZE=4,
//   FLUSH_BEATS=3). Lane expectations follow FEEDER_MIRROR_EN when defined.
// ---------------------------------------------------------------------------
module tb_skewed_operand_feeder;

  localparam logic [63:0]  ZR = 64'h0;
  localparam logic [63:0]  R0 = 64'h0004_0003_0002_0001;
  localparam logic [63:0]  R1 = 64'h0008_0007_0006_0005;
  localparam logic [63:0]  R2 = 64'h000C_000B_000A_0009;
  localparam logic [63:0]  R3 = 64'h0010_000F_000E_000D;
  localparam logic [111:0] Z  = 112'h0;
`ifdef FEEDER_MIRROR_EN
  localparam logic [111:0] B0 = 112'h0001_0002_0003_0004_0000_0000_0000;
  localparam logic [111:0] B1 = 112'h0000_0005_0006_0007_0008_0000_0000;
  localparam logic [111:0] B2 = 112'h0000_0000_0009_000A_000B_000C_0000;
  localparam logic [111:0] B3 = 112'h0000_0000_0000_000D_000E_000F_0010;
`else
  localparam logic [111:0] B0 = 112'h0000_0000_0000_0004_0003_0002_0001;
  localparam logic [111:0] B1 = 112'h0000_0000_0008_0007_0006_0005_0000;
  localparam logic [111:0] B2 = 112'h0000_000C_000B_000A_0009_0000_0000;
  localparam logic [111:0] B3 = 112'h0010_000F_000E_000D_0000_0000_0000;
`endif

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  skewed_operand_feeder_if #(.REG_WIDTH(16), .MATRIX_SIZE(4)) bus ();

  skewed_operand_feeder #(
    .REG_WIDTH   (16),
    .MATRIX_SIZE (4),
    .FLUSH_BEATS (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // One vector = inputs held for one cycle plus the outputs expected just
  // before the next edge (registered outputs reflect the previous edges).
  typedef struct {
    logic         start;
    logic         in_valid;
    logic [63:0]  in_data;
    logic         out_ready;
    logic         e_in_ready;
    logic         e_out_valid;
    logic [111:0] e_lanes;
    logic         e_cs;
    logic         e_fd;
    logic         e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int st, input int iv, input logic [63:0] d,
                              input int rdy, input int eir, input int eov,
                              input logic [111:0] el, input int ecs,
                              input int efd, input int ebusy);
    vec_t v;
    v.start       = (st != 0);
    v.in_valid    = (iv != 0);
    v.in_data     = d;
    v.out_ready   = (rdy != 0);
    v.e_in_ready  = (eir != 0);
    v.e_out_valid = (eov != 0);
    v.e_lanes     = el;
    v.e_cs        = (ecs != 0);
    v.e_fd        = (efd != 0);
    v.e_busy      = (ebusy != 0);
    return v;
  endfunction

  task automatic applyStimulus(input logic st, input logic iv,
                               input logic [63:0] d, input logic rdy);
    bus.start     = st;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [111:0] act,
                             input logic [111:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkFlag(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic checkCount(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic runVec(input vec_t v, input int idx);
    string n;
    n = $sformatf("vec%0d", idx);
    applyStimulus(v.start, v.in_valid, v.in_data, v.out_ready);
    #1;
    checkFlag({n, ".in_ready"},      bus.in_ready,      v.e_in_ready);
    checkFlag({n, ".out_valid"},     bus.out_valid,     v.e_out_valid);
    checkFlag({n, ".frame_done"},    bus.frame_done,    v.e_fd);
    checkFlag({n, ".busy"},          bus.busy,          v.e_busy);
    if (v.e_out_valid) begin
      checkOutput({n, ".out_lanes"}, bus.out_lanes,     v.e_lanes);
      checkFlag({n, ".compute_start"}, bus.compute_start, v.e_cs);
    end
    tick();
  endtask

  // Fixed 12-cycle window after the last row beat: counts beats, nonzero
  // beats and frame_done pulses, then the feeder must be idle again.
  task automatic drainFrame(input string name);
    int beats;
    int nonzero;
    int dones;
    beats = 0;
    nonzero = 0;
    dones = 0;
    applyStimulus(1'b0, 1'b0, ZR, 1'b1);
    for (int c = 0; c < 12; c++) begin
      #1;
      if (bus.out_valid === 1'b1) begin
        beats++;
        if (bus.out_lanes !== Z) nonzero++;
      end
      if (bus.frame_done === 1'b1) dones++;
      tick();
    end
    checkCount({name, ".flush_beats"},   beats,   3);
    checkCount({name, ".nonzero_flush"}, nonzero, 0);
    checkCount({name, ".frame_done_n"},  dones,   1);
    checkFlag({name, ".busy_after"},     bus.busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Test 1: back-to-back frame.
    vecs.push_back(mk(1,0,ZR,1, 0,0,Z ,0,0,0));
    vecs.push_back(mk(0,1,R0,1, 1,0,Z ,0,0,1));
    vecs.push_back(mk(0,1,R1,1, 1,1,B0,1,0,1));
    vecs.push_back(mk(0,1,R2,1, 1,1,B1,0,0,1));
    vecs.push_back(mk(0,1,R3,1, 1,1,B2,0,0,1));
    vecs.push_back(mk(0,0,ZR,1, 0,1,B3,0,0,1));
    vecs.push_back(mk(0,0,ZR,1, 0,1,Z ,0,0,1));
    vecs.push_back(mk(0,0,ZR,1, 0,1,Z ,0,0,1));
    vecs.push_back(mk(0,0,ZR,1, 0,1,Z ,0,0,1));
    vecs.push_back(mk(0,0,ZR,1, 0,0,Z ,0,1,0));
    vecs.push_back(mk(0,0,ZR,1, 0,0,Z ,0,0,0));
    // Test 3: two idle cycles between rows.
    vecs.push_back(mk(1,0,ZR,1, 0,0,Z ,0,0,0));
    vecs.push_back(mk(0,1,R0,1, 1,0,Z ,0,0,1));
    vecs.push_back(mk(0,0,ZR,1, 1,1,B0,1,0,1));
    vecs.push_back(mk(0,0,ZR,1, 1,0,Z ,0,0,1));
    vecs.push_back(mk(0,1,R1,1, 1,0,Z ,0,0,1));
    vecs.push_back(mk(0,0,ZR,1, 1,1,B1,0,0,1));
    vecs.push_back(mk(0,0,ZR,1, 1,0,Z ,0,0,1));
    vecs.push_back(mk(0,1,R2,1, 1,0,Z ,0,0,1));
    vecs.push_back(mk(0,0,ZR,1, 1,1,B2,0,0,1));
    vecs.push_back(mk(0,0,ZR,1, 1,0,Z ,0,0,1));
    vecs.push_back(mk(0,1,R3,1, 1,0,Z ,0,0,1));
    vecs.push_back(mk(0,0,ZR,1, 0,1,B3,0,0,1));
    vecs.push_back(mk(0,0,ZR,1, 0,1,Z ,0,0,1));
    vecs.push_back(mk(0,0,ZR,1, 0,1,Z ,0,0,1));
    vecs.push_back(mk(0,0,ZR,1, 0,1,Z ,0,0,1));
    vecs.push_back(mk(0,0,ZR,1, 0,0,Z ,0,1,0));
    vecs.push_back(mk(0,0,ZR,1, 0,0,Z ,0,0,0));
    // Test 5: start pulsed during LOAD and FLUSH has no effect.
    vecs.push_back(mk(1,0,ZR,1, 0,0,Z ,0,0,0));
    vecs.push_back(mk(0,1,R0,1, 1,0,Z ,0,0,1));
    vecs.push_back(mk(1,1,R1,1, 1,1,B0,1,0,1));
    vecs.push_back(mk(0,1,R2,1, 1,1,B1,0,0,1));
    vecs.push_back(mk(0,1,R3,1, 1,1,B2,0,0,1));
    vecs.push_back(mk(0,0,ZR,1, 0,1,B3,0,0,1));
    vecs.push_back(mk(1,0,ZR,1, 0,1,Z ,0,0,1));
    vecs.push_back(mk(0,0,ZR,1, 0,1,Z ,0,0,1));
    vecs.push_back(mk(0,0,ZR,1, 0,1,Z ,0,0,1));
    vecs.push_back(mk(0,0,ZR,1, 0,0,Z ,0,1,0));
    vecs.push_back(mk(0,0,ZR,1, 0,0,Z ,0,0,0));
    vecs.push_back(mk(0,0,ZR,1, 0,0,Z ,0,0,0));

    // Reset state.
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, ZR, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    checkFlag("reset.out_valid",     bus.out_valid,     1'b0);
    checkFlag("reset.compute_start", bus.compute_start, 1'b0);
    checkFlag("reset.frame_done",    bus.frame_done,    1'b0);
    checkFlag("reset.in_ready",      bus.in_ready,      1'b0);
    checkFlag("reset.busy",          bus.busy,          1'b0);
    checkOutput("reset.out_lanes",   bus.out_lanes,     Z);
    reset = 1'b0;

    foreach (vecs[i]) runVec(vecs[i], i);

    // Test 2: five-cycle stall while beat 2 is on the lanes.
    applyStimulus(1'b1, 1'b0, ZR, 1'b1); tick();
    applyStimulus(1'b0, 1'b1, R0, 1'b1); tick();
    applyStimulus(1'b0, 1'b1, R1, 1'b1); tick();
    applyStimulus(1'b0, 1'b1, R2, 1'b1); tick();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b1, R3, 1'b0);
      #1;
      checkFlag($sformatf("stall%0d.out_valid", k), bus.out_valid, 1'b1);
      checkOutput($sformatf("stall%0d.out_lanes", k), bus.out_lanes, B2);
      checkFlag($sformatf("stall%0d.in_ready", k), bus.in_ready, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 1'b1, R3, 1'b1);
    #1;
    checkFlag("release.in_ready", bus.in_ready, 1'b1);
    checkOutput("release.out_lanes", bus.out_lanes, B2);
    tick();
    applyStimulus(1'b0, 1'b0, ZR, 1'b1);
    #1;
    checkOutput("release.beat3", bus.out_lanes, B3);
    checkFlag("release.beat3_valid", bus.out_valid, 1'b1);
    tick();
    drainFrame("stall");

    // Test 4: reset after the second row, then a fresh frame.
    applyStimulus(1'b1, 1'b0, ZR, 1'b1); tick();
    applyStimulus(1'b0, 1'b1, R0, 1'b1); tick();
    applyStimulus(1'b0, 1'b1, R1, 1'b1); tick();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, R2, 1'b1); tick();
    #1;
    checkFlag("midreset.out_valid",     bus.out_valid,     1'b0);
    checkFlag("midreset.compute_start", bus.compute_start, 1'b0);
    checkFlag("midreset.frame_done",    bus.frame_done,    1'b0);
    checkFlag("midreset.in_ready",      bus.in_ready,      1'b0);
    checkFlag("midreset.busy",          bus.busy,          1'b0);
    checkOutput("midreset.out_lanes",   bus.out_lanes,     Z);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, ZR, 1'b1); tick();
    applyStimulus(1'b0, 1'b1, R0, 1'b1); tick();
    applyStimulus(1'b0, 1'b1, R1, 1'b1);
    #1;
    checkOutput("restart.beat0", bus.out_lanes, B0);
    checkFlag("restart.compute_start", bus.compute_start, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, R2, 1'b1); tick();
    applyStimulus(1'b0, 1'b1, R3, 1'b1); tick();
    applyStimulus(1'b0, 1'b0, ZR, 1'b1);
    #1;
    checkOutput("restart.beat3", bus.out_lanes, B3);
    tick();
    drainFrame("restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
